// File: rtl/sr_jk_t_from_d_register.sv
`default_nettype none
// ============================================================================
// Module   : sr_jk_t_from_d_register
// Brief    : WIDTH-bit D-flop register emulating D/SR/JK/T per bit, with
//            detection and saturating count of the forbidden SR input (S=R=1).
// Revision : 1.0 - initial release
// ============================================================================
module sr_jk_t_from_d_register #(
  parameter int               WIDTH     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             illegal,
  output logic [WIDTH-1:0] illegal_mask,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] C_MODE_D  = 2'b00;
  localparam logic [1:0] C_MODE_SR = 2'b01;
  localparam logic [1:0] C_MODE_JK = 2'b10;
  localparam logic [1:0] C_MODE_T  = 2'b11;

  logic [WIDTH-1:0] state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (mode)
        C_MODE_D:  state_d = a;
        // S=R=1 falls out of this expression as a hold
        C_MODE_SR: state_d = (state_q & ~(b & ~a)) | (a & ~b);
        C_MODE_JK: state_d = (a & ~state_q) | (~b & state_q);
        C_MODE_T:  state_d = state_q ^ a;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    illegal_d = en && (mode == C_MODE_SR) && (|(a & b));
    mask_d    = illegal_d ? (a & b) : {WIDTH{1'b0}};
    sticky_d  = sticky_q;
    count_d   = count_q;
    if (illegal_d) begin
      sticky_d = 1'b1;
      // A simultaneous clear restarts the count at this event
      if (clr_err)
        count_d = CNT_W'(1);
      else if (!(&count_q))
        count_d = count_q + CNT_W'(1);
    end else if (clr_err) begin
      sticky_d = 1'b0;
      count_d  = {CNT_W{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_VAL;
      illegal_q <= 1'b0;
      mask_q    <= {WIDTH{1'b0}};
      sticky_q  <= 1'b0;
      count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      mask_q    <= mask_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
    end
  end

  assign q            = state_q;
  assign q_bar        = ~state_q;
  assign illegal      = illegal_q;
  assign illegal_mask = mask_q;
  assign err_sticky   = sticky_q;
  assign err_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_jk_t_from_d_register.sv
`default_nettype none
// Bench for sr_jk_t_from_d_register: vector table plus hand-built multi-cycle
// sequences, expectations queued at drive time and popped after each edge.
module tb_sr_jk_t_from_d_register;

  localparam int         W    = 4;
  localparam int         CW   = 2;
  localparam logic [3:0] RVAL = 4'b0101;

  logic          clk = 1'b0;
  logic          rst, en, clr_err;
  logic [1:0]    mode;
  logic [W-1:0]  a, b;
  logic [W-1:0]  q, q_bar, illegal_mask;
  logic          illegal, err_sticky;
  logic [CW-1:0] err_count;

  sr_jk_t_from_d_register #(.WIDTH(W), .CNT_W(CW), .RESET_VAL(RVAL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .clr_err(clr_err), .q(q), .q_bar(q_bar), .illegal(illegal),
    .illegal_mask(illegal_mask), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, en, clr;
    logic [1:0]    mode;
    logic [W-1:0]  a, b;
    logic [W-1:0]  eq;
    logic          eill;
    logic [W-1:0]  emask;
    logic          est;
    logic [CW-1:0] ecnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(logic r, logic e, logic c, logic [1:0] m,
                              logic [3:0] ia, logic [3:0] ib, logic [3:0] eq,
                              logic ei, logic [3:0] em, logic es, logic [1:0] ec);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.mode = m; v.a = ia; v.b = ib;
    v.eq = eq; v.eill = ei; v.emask = em; v.est = es; v.ecnt = ec;
    return v;
  endfunction

  task automatic check(input int idx);
    vec_t e;
    e = sb.pop_front();
    n_vec++;
    if (q !== e.eq) begin
      n_miss++; $display("FAIL v%0d q: got %b want %b", idx, q, e.eq);
    end
    if (q_bar !== ~e.eq) begin
      n_miss++; $display("FAIL v%0d q_bar: got %b want %b", idx, q_bar, ~e.eq);
    end
    if (illegal !== e.eill) begin
      n_miss++; $display("FAIL v%0d illegal: got %b want %b", idx, illegal, e.eill);
    end
    if (illegal_mask !== e.emask) begin
      n_miss++; $display("FAIL v%0d mask: got %b want %b", idx, illegal_mask, e.emask);
    end
    if (err_sticky !== e.est) begin
      n_miss++; $display("FAIL v%0d sticky: got %b want %b", idx, err_sticky, e.est);
    end
    if (err_count !== e.ecnt) begin
      n_miss++; $display("FAIL v%0d count: got %0d want %0d", idx, err_count, e.ecnt);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst = v.rst; en = v.en; clr_err = v.clr; mode = v.mode; a = v.a; b = v.b;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; clr_err = 1'b0; mode = 2'b00; a = '0; b = '0;

    //            rst en clr mode   a        b        q        ill mask     st cnt
    tbl.push_back(mk(1, 0, 0, 2'b00, 4'b0000, 4'b0000, 4'b0101, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 4'b1100, 4'b0000, 4'b1100, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 4'b0011, 4'b0100, 4'b0011, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 4'b0000, 4'b0010, 4'b0001, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 4'b1010, 4'b0110, 4'b1001, 1, 4'b0010, 1, 2'd1));
    tbl.push_back(mk(0, 1, 0, 2'b01, 4'b0000, 4'b0000, 4'b1001, 0, 4'b0000, 1, 2'd1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 4'b0110, 4'b0000, 4'b0110, 0, 4'b0000, 1, 2'd1));
    tbl.push_back(mk(0, 1, 0, 2'b10, 4'b1111, 4'b1111, 4'b1001, 0, 4'b0000, 1, 2'd1));
    tbl.push_back(mk(0, 1, 0, 2'b11, 4'b0011, 4'b1111, 4'b1010, 0, 4'b0000, 1, 2'd1));
    tbl.push_back(mk(0, 0, 0, 2'b01, 4'b1111, 4'b1111, 4'b1010, 0, 4'b0000, 1, 2'd1));
    tbl.push_back(mk(0, 0, 1, 2'b00, 4'b0101, 4'b0000, 4'b1010, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 4'b1000, 4'b0010, 4'b1000, 0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 4'b0010, 4'b1000, 4'b0010, 0, 4'b0000, 0, 2'd0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Saturation: forbidden bit0 held five cycles, count sticks at 3
    for (int i = 0; i < 5; i++)
      apply(mk(0, 1, 0, 2'b01, 4'b0001, 4'b0001, 4'b0010, 1, 4'b0001, 1,
               (i < 2) ? 2'(i + 1) : 2'd3), 100 + i);

    // Clear alone, then clear colliding with an event, then a second event
    apply(mk(0, 0, 1, 2'b01, 4'b1111, 4'b1111, 4'b0010, 0, 4'b0000, 0, 2'd0), 200);
    apply(mk(0, 1, 1, 2'b01, 4'b0100, 4'b0100, 4'b0010, 1, 4'b0100, 1, 2'd1), 201);
    apply(mk(0, 1, 0, 2'b01, 4'b1111, 4'b0011, 4'b1110, 1, 4'b0011, 1, 2'd2), 202);

    // Reset wins over a pending forbidden input and a clear
    apply(mk(1, 1, 1, 2'b01, 4'b1111, 4'b1111, 4'b0101, 0, 4'b0000, 0, 2'd0), 300);
    apply(mk(0, 1, 0, 2'b11, 4'b1111, 4'b0000, 4'b1010, 0, 4'b0000, 0, 2'd0), 301);
    apply(mk(0, 1, 0, 2'b10, 4'b0000, 4'b0000, 4'b1010, 0, 4'b0000, 0, 2'd0), 302);

    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
